result_colour_queue: RTL and testbench

Buffers finished per-pixel results from the Mandelbrot engine and converts them to 24-bit RGB pixels on a ready/valid output stream. It sits directly downstream of the engine. It drives the engine's `full_queue` back-pressure input, and it accepts a result on any cycle where `wr_en` is high and the queue is not full. The output side feeds the video packet writer, with start/end-of-frame markers derived from pixel coordinates.

---
 rtl/result_colour_queue.sv | 140 ++++++++++++++
 tb/tb_result_colour_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_colour_queue.sv
`default_nettype none
// ============================================================================
// Module   : result_colour_queue
// Purpose  : Buffers finished per-pixel Mandelbrot results in a small
//            circular queue and converts each one to a 24-bit {R,G,B} pixel
//            on a ready/valid output stream with start/end-of-frame markers.
// Ports    : clk, reset (async, active low)
//            iterations_max              - escape limit, sampled at pop time
//            wr_en / wr_iterations /
//            wr_xpixel / wr_ypixel       - engine result write port
//            full_queue, level, overflow - queue status / back-pressure
//            out_valid / out_ready       - output handshake
//            out_data, out_xpixel, out_ypixel, out_sop, out_eop
// Revision : 1.0 - initial release
// ============================================================================
module result_colour_queue #(
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int ITERATIONS_WIDTH = 32,
  parameter int DEPTH            = 8,
  parameter int X_PIXELS         = 640,
  parameter int Y_PIXELS         = 480
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ITERATIONS_WIDTH-1:0]       iterations_max,
  input  logic                              wr_en,
  input  logic [ITERATIONS_WIDTH-1:0]       wr_iterations,
  input  logic [PIXEL_DATA_WIDTH-1:0]       wr_xpixel,
  input  logic [PIXEL_DATA_WIDTH-1:0]       wr_ypixel,
  output logic                              full_queue,
  output logic [$clog2(DEPTH+1)-1:0]        level,
  output logic                              overflow,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [23:0]                       out_data,
  output logic [PIXEL_DATA_WIDTH-1:0]       out_xpixel,
  output logic [PIXEL_DATA_WIDTH-1:0]       out_ypixel,
  output logic                              out_sop,
  output logic                              out_eop
);

  localparam int c_ptr_w   = $clog2(DEPTH);
  localparam int c_lvl_w   = $clog2(DEPTH+1);
  localparam int c_entry_w = ITERATIONS_WIDTH + 2*PIXEL_DATA_WIDTH;

  localparam logic [c_lvl_w-1:0]          c_full_level = c_lvl_w'(DEPTH);
  localparam logic [PIXEL_DATA_WIDTH-1:0] c_x_last     = PIXEL_DATA_WIDTH'(X_PIXELS-1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] c_y_last     = PIXEL_DATA_WIDTH'(Y_PIXELS-1);

  // Storage is deliberately not reset so it can map onto plain RAM.
  logic [c_entry_w-1:0] r_mem [DEPTH];

  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0] r_level;

  logic                        w_push;
  logic                        w_load;
  logic [c_entry_w-1:0]        w_head;
  logic [ITERATIONS_WIDTH-1:0] w_head_iter;
  logic [PIXEL_DATA_WIDTH-1:0] w_head_x;
  logic [PIXEL_DATA_WIDTH-1:0] w_head_y;
  logic [23:0]                 w_colour;

  assign level      = r_level;
  assign full_queue = (r_level == c_full_level);

  // Full is judged on the pre-edge level, so a push while full is refused
  // even if a pop happens on the same edge.
  assign w_push = wr_en & ~full_queue;
  assign w_load = (r_level != '0) & (~out_valid | out_ready);

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_iter = w_head[c_entry_w-1 -: ITERATIONS_WIDTH];
  assign w_head_x    = w_head[2*PIXEL_DATA_WIDTH-1 -: PIXEL_DATA_WIDTH];
  assign w_head_y    = w_head[PIXEL_DATA_WIDTH-1:0];

  // Points that never escaped are painted black; others get a cheap
  // gradient built from the low iteration bits.
  always_comb begin
    w_colour = 24'h000000;
    if (w_head_iter < iterations_max) begin
      w_colour = {w_head_iter[7:0], w_head_iter[6:0], 1'b0, ~w_head_iter[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_iterations, wr_xpixel, wr_ypixel};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_load})
        2'b10:   r_level <= r_level + c_lvl_w'(1);
        2'b01:   r_level <= r_level - c_lvl_w'(1);
        default: r_level <= r_level;
      endcase
      if (wr_en && full_queue) begin
        overflow <= 1'b1;
      end
    end
  end

  // Single output stage: refilled whenever it is empty or being consumed,
  // otherwise every out_* field holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_xpixel <= '0;
      out_ypixel <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
    end else if (w_load) begin
      out_valid  <= 1'b1;
      out_data   <= w_colour;
      out_xpixel <= w_head_x;
      out_ypixel <= w_head_y;
      out_sop    <= (w_head_x == '0) && (w_head_y == '0);
      out_eop    <= (w_head_x == c_x_last) && (w_head_y == c_y_last);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_colour_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_colour_queue
// Purpose  : Self-checking bench for result_colour_queue. A queue-based
//            model tracks stored results and the output slot; each cycle the
//            DUT outputs are compared against it, with a few hand-computed
//            values pinning the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_colour_queue;

  localparam int PW    = 10;
  localparam int IW    = 32;
  localparam int DEPTH = 8;
  localparam int XP    = 640;
  localparam int YP    = 480;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] iterations_max;
  logic          wr_en;
  logic [IW-1:0] wr_iterations;
  logic [PW-1:0] wr_xpixel;
  logic [PW-1:0] wr_ypixel;
  logic          full_queue;
  logic [3:0]    level;
  logic          overflow;
  logic          out_valid;
  logic          out_ready;
  logic [23:0]   out_data;
  logic [PW-1:0] out_xpixel;
  logic [PW-1:0] out_ypixel;
  logic          out_sop;
  logic          out_eop;

  result_colour_queue #(
    .PIXEL_DATA_WIDTH(PW),
    .ITERATIONS_WIDTH(IW),
    .DEPTH(DEPTH),
    .X_PIXELS(XP),
    .Y_PIXELS(YP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .iterations_max(iterations_max),
    .wr_en(wr_en),
    .wr_iterations(wr_iterations),
    .wr_xpixel(wr_xpixel),
    .wr_ypixel(wr_ypixel),
    .full_queue(full_queue),
    .level(level),
    .overflow(overflow),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_xpixel(out_xpixel),
    .out_ypixel(out_ypixel),
    .out_sop(out_sop),
    .out_eop(out_eop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint iter;
    int     x;
    int     y;
  } entry_t;

  entry_t m_q[$];
  bit     m_valid = 0;
  bit     m_ovf   = 0;
  longint m_data  = 0;
  int     m_x     = 0;
  int     m_y     = 0;
  bit     m_sop   = 0;
  bit     m_eop   = 0;
  bit     m_full;
  bit     m_push;
  bit     m_load;
  entry_t m_e;

  function automatic longint colour(input longint i, input longint imax);
    longint r, g, b;
    if (i >= imax) return 0;
    r = i % 256;
    g = (i * 2) % 256;
    b = 255 - r;
    return r * 65536 + g * 256 + b;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_q.delete();
      m_valid = 0; m_ovf = 0;
      m_data = 0; m_x = 0; m_y = 0; m_sop = 0; m_eop = 0;
    end else begin
      m_full = (m_q.size() == DEPTH);
      m_push = wr_en && !m_full;
      m_load = (m_q.size() != 0) && (!m_valid || out_ready);
      if (wr_en && m_full) m_ovf = 1;
      if (m_load) begin
        m_e     = m_q.pop_front();
        m_data  = colour(m_e.iter, longint'(iterations_max));
        m_x     = m_e.x;
        m_y     = m_e.y;
        m_sop   = (m_e.x == 0) && (m_e.y == 0);
        m_eop   = (m_e.x == XP-1) && (m_e.y == YP-1);
        m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (m_push) m_q.push_back('{longint'(wr_iterations), int'(wr_xpixel), int'(wr_ypixel)});
    end
    #1;
    check("out_valid", out_valid, m_valid);
    check("level", level, m_q.size());
    check("full_queue", full_queue, m_q.size() == DEPTH);
    check("overflow", overflow, m_ovf);
    if (m_valid || !reset) begin
      check("out_data", out_data, m_data);
      check("out_xpixel", out_xpixel, m_x);
      check("out_ypixel", out_ypixel, m_y);
      check("out_sop", out_sop, m_sop);
      check("out_eop", out_eop, m_eop);
    end
  end

  // ---------------- stimulus ----------------
  int seq = 1;

  task automatic drive_entry(input longint i, input int x, input int y);
    wr_en         = 1'b1;
    wr_iterations = IW'(i);
    wr_xpixel     = PW'(x);
    wr_ypixel     = PW'(y);
  endtask

  // Ordered entry: coordinates encode the sequence number so order and
  // duplicates show up in the per-cycle comparison.
  task automatic drive_seq();
    drive_entry($urandom_range(0, 150), (seq % XP), (seq / XP) % YP);
    seq++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    reset          = 1'b0;
    iterations_max = 32'd100;
    wr_en          = 1'b0;
    wr_iterations  = '0;
    wr_xpixel      = '0;
    wr_ypixel      = '0;
    out_ready      = 1'b0;
    idle(3);
    check("rst out_valid", out_valid, 0);
    check("rst level", level, 0);
    check("rst full_queue", full_queue, 0);
    check("rst overflow", overflow, 0);
    check("rst out_data", out_data, 0);
    check("rst out_sop", out_sop, 0);
    check("rst out_eop", out_eop, 0);
    check("rst out_xy", {out_xpixel, out_ypixel}, 0);
    reset = 1'b1;
    idle(2);

    // single pixel: i=5 at (0,0)
    out_ready = 1'b1;
    drive_entry(5, 0, 0);
    @(negedge clk); wr_en = 1'b0;
    check("lat1 out_valid", out_valid, 0);
    @(negedge clk);
    check("lat2 out_valid", out_valid, 1);
    check("pix5 out_data", out_data, 24'h050AFA);
    check("pix5 out_sop", out_sop, 1);
    check("pix5 out_eop", out_eop, 0);
    @(negedge clk);

    // i = iterations_max at the last frame pixel
    drive_entry(100, XP-1, YP-1);
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    check("pixmax out_valid", out_valid, 1);
    check("pixmax out_data", out_data, 0);
    check("pixmax out_eop", out_eop, 1);
    check("pixmax out_sop", out_sop, 0);
    idle(2);

    // fill against a stalled output
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_seq();
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("fill level", level, 8);
    check("fill full_queue", full_queue, 1);
    check("fill overflow", overflow, 1);
    check("fill out_valid", out_valid, 1);

    // drain in order
    out_ready = 1'b1;
    idle(12);
    check("drain level", level, 0);
    check("drain out_valid", out_valid, 0);

    // hold level at 3 with concurrent push/pop
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_seq();
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check("pp level", level, 3);
      drive_seq();
      @(negedge clk);
    end
    wr_en = 1'b0;
    idle(8);

    // random traffic, random back-pressure, occasional frame corners
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) iterations_max = IW'($urandom_range(40, 200));
      out_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 5))
          0:       drive_entry($urandom_range(0, 300), 0, 0);
          1:       drive_entry($urandom_range(0, 300), XP-1, YP-1);
          2:       drive_entry(longint'($urandom()), $urandom_range(0, XP-1), $urandom_range(0, YP-1));
          default: drive_entry($urandom_range(0, 300), $urandom_range(0, XP-1), $urandom_range(0, YP-1));
        endcase
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;

    // reset mid-stream with five entries queued
    out_ready = 1'b1;
    idle(12);
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive_seq();
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("pre-rst level", level, 5);
    reset = 1'b0;
    #1;
    check("async rst level", level, 0);
    check("async rst out_valid", out_valid, 0);
    check("async rst full_queue", full_queue, 0);
    check("async rst out_data", out_data, 0);
    idle(2);
    reset = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post-rst no stale", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
